// File: rtl/call_stack.sv
// call_stack: hardware return-address stack for the 8-bit CPU.
// CALL pushes pcin; RET pops the top entry and presents it on pcout with a
// one-cycle pcoe pulse, one clock after ret is sampled.
// Optional build macro: CALL_STACK_WRAP_EN. When it is defined, a push while
// full overwrites the oldest entry. When it is undefined, that push is dropped.
module call_stack #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            call,
  input  logic            ret,
  input  logic [PC_W-1:0] pcin,
  output logic            pcoe,
  output logic [PC_W-1:0] pcout,
  output logic            empty,
  output logic            full,
  output logic            overflow,
  output logic            underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] HEAD_ONE = 1;
  localparam logic [CW-1:0] CNT_ONE  = 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PC_W-1:0] mem [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   top;
  logic [CW-1:0]   count;

  logic            pop_ok;
  logic            swap;
  logic            push_ok;
  logic            push_full;
  logic            wrap_push;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;

  assign top   = head - HEAD_ONE;
  assign empty = (count == '0);
  assign full  = (count == CNT_FULL);

  // Decode the request into the single action taken this cycle.
  always_comb begin
    pop_ok    = ret && !empty;
    swap      = call && pop_ok;
    push_ok   = call && !pop_ok && !full;
    push_full = call && !pop_ok && full;
`ifdef CALL_STACK_WRAP_EN
    wrap_push = push_full;
`else
    wrap_push = 1'b0;
`endif
    mem_we    = push_ok || swap || wrap_push;
    mem_waddr = swap ? top : head;
  end

  // Return-address storage. A swap replaces the top entry, and a push fills the next free slot.
  always_ff @(posedge clk) begin
    if (reset && mem_we) begin
      mem[mem_waddr] <= pcin;
    end
  end

  // Pointer, occupancy, pop pulse and sticky error flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head      <= '0;
      count     <= '0;
      pcoe      <= 1'b0;
      pcout     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pcoe  <= pop_ok;
      pcout <= pop_ok ? mem[top] : '0;
      if (pop_ok && !call) begin
        head  <= top;
        count <= count - CNT_ONE;
      end else if (push_ok) begin
        head  <= head + HEAD_ONE;
        count <= count + CNT_ONE;
      end else if (wrap_push) begin
        head  <= head + HEAD_ONE;
      end
      if (ret && empty) begin
        underflow <= 1'b1;
      end
      if (push_full) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule
